// File: rtl/bnn_pkg.sv
// Shared BNN OCR pipeline definitions used by the argmax classifier.
// Optional runner-up tracking is enabled with ARGMAX_MARGIN_EN.
package bnn_pkg;

    typedef logic signed [15:0] score_t;

    localparam int NUM_CLASSES_DEFAULT = 10;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;

endpackage

// File: rtl/argmax_classifier_if.sv
// Score-capture and result-readout bus of the argmax classifier.
// With ARGMAX_MARGIN_EN the bus also carries margin and low_conf.
interface argmax_classifier_if #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 16
);
    localparam int IDX_W = $clog2(NUM_CLASSES);

    logic                                scores_valid;
    logic [NUM_CLASSES-1:0][SCORE_W-1:0] scores;
    logic                                result_ack;
    logic                                result_valid;
    logic [IDX_W-1:0]                    class_idx;
    logic [SCORE_W-1:0]                  max_score;
    logic                                busy;
    logic                                overrun;
`ifdef ARGMAX_MARGIN_EN
    logic [SCORE_W:0]                    margin;
    logic                                low_conf;
`endif

    modport master (
        output scores_valid, scores, result_ack,
        input  result_valid, class_idx, max_score, busy, overrun
`ifdef ARGMAX_MARGIN_EN
        , input margin, low_conf
`endif
    );

    modport slave (
        input  scores_valid, scores, result_ack,
        output result_valid, class_idx, max_score, busy, overrun
`ifdef ARGMAX_MARGIN_EN
        , output margin, low_conf
`endif
    );

endinterface

// File: rtl/argmax_classifier_score_cmp.sv
// Signed candidate-versus-best compare; with ARGMAX_MARGIN_EN also versus the runner-up.
module score_cmp #(
    parameter int SCORE_W = 16
) (
    input  logic [SCORE_W-1:0] cand,
    input  logic [SCORE_W-1:0] best,
    output logic               best_upd
`ifdef ARGMAX_MARGIN_EN
    ,
    input  logic [SCORE_W-1:0] second,
    output logic               second_upd
`endif
);

    // Strict compare keeps the lowest index on ties.
    assign best_upd = $signed(cand) > $signed(best);

`ifdef ARGMAX_MARGIN_EN
    assign second_upd = !best_upd && ($signed(cand) > $signed(second));
`endif

endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over captured class scores with a valid/ack result hold.
// ARGMAX_MARGIN_EN adds runner-up tracking with margin and low_conf outputs.
module argmax_classifier
    import bnn_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEFAULT,
    parameter int SCORE_W     = 16
`ifdef ARGMAX_MARGIN_EN
    ,
    parameter logic [SCORE_W-1:0] MARGIN_THRESH = 16'sh0100
`endif
) (
    input logic                clk,
    input logic                rst,
    argmax_classifier_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    argmax_state_t      state;
    logic               valid_q;
    logic [SCORE_W-1:0] cap [NUM_CLASSES];
    logic [SCORE_W-1:0] best;
    logic [IDX_W-1:0]   best_idx;
    logic [IDX_W-1:0]   i;
    logic               overrun_q;
    logic               new_frame;
    logic               capture;
    logic               best_upd;
    logic [SCORE_W-1:0] cand;

    assign new_frame = bus.scores_valid & ~valid_q;
    assign capture   = new_frame && (state == IDLE || state == DONE);
    assign cand      = cap[i];

`ifdef ARGMAX_MARGIN_EN
    logic [SCORE_W-1:0]        second;
    logic                      second_upd;
    logic signed [SCORE_W:0]   diff;

    score_cmp #(.SCORE_W(SCORE_W)) u_cmp (
        .cand       (cand),
        .best       (best),
        .best_upd   (best_upd),
        .second     (second),
        .second_upd (second_upd)
    );
`else
    score_cmp #(.SCORE_W(SCORE_W)) u_cmp (
        .cand     (cand),
        .best     (best),
        .best_upd (best_upd)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid_q   <= 1'b0;
            best      <= '0;
            best_idx  <= '0;
            i         <= '0;
            overrun_q <= 1'b0;
            for (int unsigned k = 0; k < NUM_CLASSES; k++) cap[k] <= '0;
`ifdef ARGMAX_MARGIN_EN
            second    <= '0;
`endif
        end else begin
            valid_q   <= bus.scores_valid;
            // Edges in SCAN are dropped; in DONE they only count as overrun when unacknowledged.
            overrun_q <= new_frame && (state == SCAN || (state == DONE && !bus.result_ack));
            if (capture) begin
                for (int unsigned k = 0; k < NUM_CLASSES; k++) cap[k] <= bus.scores[k];
                best     <= bus.scores[0];
                best_idx <= '0;
                i        <= IDX_W'(1);
                state    <= SCAN;
`ifdef ARGMAX_MARGIN_EN
                second   <= {1'b1, {(SCORE_W-1){1'b0}}};
`endif
            end else begin
                case (state)
                    SCAN: begin
                        if (best_upd) begin
                            best     <= cand;
                            best_idx <= i;
`ifdef ARGMAX_MARGIN_EN
                            second   <= best;
`endif
                        end
`ifdef ARGMAX_MARGIN_EN
                        else if (second_upd) second <= cand;
`endif
                        if (i == LAST_IDX) state <= DONE;
                        else               i     <= i + IDX_W'(1);
                    end
                    DONE:    if (bus.result_ack) state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign bus.result_valid = (state == DONE);
    assign bus.class_idx    = best_idx;
    assign bus.max_score    = best;
    assign bus.busy         = (state == SCAN);
    assign bus.overrun      = overrun_q;

`ifdef ARGMAX_MARGIN_EN
    assign diff         = $signed({best[SCORE_W-1], best}) - $signed({second[SCORE_W-1], second});
    assign bus.margin   = bus.result_valid ? diff : '0;
    assign bus.low_conf = bus.result_valid &&
                          (diff < $signed({MARGIN_THRESH[SCORE_W-1], MARGIN_THRESH}));
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed self-checking bench for argmax_classifier; margin checks compile in with ARGMAX_MARGIN_EN.
module tb_argmax_classifier;
    import bnn_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    argmax_classifier_if #(.NUM_CLASSES(10), .SCORE_W(16)) bus ();

    argmax_classifier #(.NUM_CLASSES(10), .SCORE_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.result_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk(tag, {31'b0, bus.result_valid}, 32'd1);
    endtask

    task automatic ack_result();
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
    endtask

    logic [9:0][15:0] s;
    logic [9:0][15:0] s_b;
    int               ov_cnt;
    int               rise_cnt;
    logic             prev_rv;

    initial begin
        rst              = 1'b1;
        bus.scores_valid = 1'b0;
        bus.result_ack   = 1'b0;
        bus.scores       = '0;
        step();
        step();
        chk("reset_valid", {31'b0, bus.result_valid}, 32'd0);
        chk("reset_idx",   {28'b0, bus.class_idx},    32'd0);
        chk("reset_score", {16'b0, bus.max_score},    32'd0);
        chk("reset_busy",  {31'b0, bus.busy},         32'd0);
        chk("reset_ovr",   {31'b0, bus.overrun},      32'd0);
        rst = 1'b0;
        step();

        // 1: ascending scores, exact latency
        for (int k = 0; k < 10; k++) s[k] = 16'(k * 256);
        bus.scores = s;
        bus.scores_valid = 1'b1;
        step();
        bus.scores_valid = 1'b0;
        chk("t1_busy", {31'b0, bus.busy}, 32'd1);
        for (int k = 1; k < 9; k++) begin
            step();
            chk("t1_not_yet", {31'b0, bus.result_valid}, 32'd0);
        end
        step();
        chk("t1_valid_at_9", {31'b0, bus.result_valid}, 32'd1);
        chk("t1_idx",   {28'b0, bus.class_idx}, 32'd9);
        chk("t1_score", {16'b0, bus.max_score}, 32'h0900);
`ifdef ARGMAX_MARGIN_EN
        chk("t1_margin",  {15'b0, bus.margin}, 32'h0100);
        chk("t1_lowconf", {31'b0, bus.low_conf}, 32'd0);
`endif
        step();
        chk("t1_hold", {28'b0, bus.class_idx}, 32'd9);
        ack_result();
        chk("t1_ack_valid", {31'b0, bus.result_valid}, 32'd0);
        chk("t1_ack_busy",  {31'b0, bus.busy},         32'd0);

        // 2: all negative, max -0.5 at idx 3
        for (int k = 0; k < 10; k++) s[k] = 16'hF000;
        s[0] = 16'hFE00; s[1] = 16'hFC00; s[2] = 16'h8000; s[3] = 16'hFF80; s[9] = 16'hFE00;
        bus.scores = s;
        bus.scores_valid = 1'b1;
        step();
        bus.scores_valid = 1'b0;
        wait_done("t2_done");
        chk("t2_idx",   {28'b0, bus.class_idx}, 32'd3);
        chk("t2_score", {16'b0, bus.max_score}, 32'hFF80);
        ack_result();

        // 2b: one small positive beats large-unsigned negatives
        for (int k = 0; k < 10; k++) s[k] = 16'hFF00;
        s[5] = 16'h0010;
        bus.scores = s;
        bus.scores_valid = 1'b1;
        step();
        bus.scores_valid = 1'b0;
        wait_done("t2b_done");
        chk("t2b_idx",   {28'b0, bus.class_idx}, 32'd5);
        chk("t2b_score", {16'b0, bus.max_score}, 32'h0010);
        ack_result();

        // 3: tie between idx 2 and 7
        for (int k = 0; k < 10; k++) s[k] = 16'h0100;
        s[2] = 16'h0400; s[7] = 16'h0400;
        bus.scores = s;
        bus.scores_valid = 1'b1;
        step();
        bus.scores_valid = 1'b0;
        wait_done("t3_done");
        chk("t3_idx",   {28'b0, bus.class_idx}, 32'd2);
        chk("t3_score", {16'b0, bus.max_score}, 32'h0400);
`ifdef ARGMAX_MARGIN_EN
        chk("t3_margin",  {15'b0, bus.margin}, 32'd0);
        chk("t3_lowconf", {31'b0, bus.low_conf}, 32'd1);
`endif
        ack_result();

        // 4: scores_valid held for 30 cycles without ack
        for (int k = 0; k < 10; k++) s[k] = 16'(k * 16);
        s[4] = 16'h0600;
        bus.scores = s;
        bus.scores_valid = 1'b1;
        rise_cnt = 0;
        ov_cnt = 0;
        prev_rv = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.result_valid && !prev_rv) rise_cnt++;
            if (bus.overrun) ov_cnt++;
            prev_rv = bus.result_valid;
        end
        chk("t4_one_result", rise_cnt, 32'd1);
        chk("t4_no_overrun", ov_cnt,   32'd0);
        chk("t4_still_valid", {31'b0, bus.result_valid}, 32'd1);
        chk("t4_idx", {28'b0, bus.class_idx}, 32'd4);
        ack_result();
        chk("t4_ack_valid", {31'b0, bus.result_valid}, 32'd0);
        chk("t4_ack_idle",  {31'b0, bus.busy},         32'd0);
        step();
        chk("t4_no_retrig", {31'b0, bus.busy}, 32'd0);
        bus.scores_valid = 1'b0;
        step();

        // 5: re-raise mid-scan, then again in DONE without ack
        for (int k = 0; k < 10; k++) s[k] = 16'h0100;
        s[4] = 16'h0700;
        s_b = '0;
        s_b[1] = 16'h7000;
        bus.scores = s;
        bus.scores_valid = 1'b1;
        step();
        step();
        step();
        bus.scores_valid = 1'b0;
        step();
        bus.scores = s_b;
        bus.scores_valid = 1'b1;
        step();
        chk("t5_scan_overrun", {31'b0, bus.overrun}, 32'd1);
        ov_cnt = 1;
        for (int n = 0; n < 30 && bus.result_valid !== 1'b1; n++) begin
            step();
            if (bus.overrun) ov_cnt++;
        end
        chk("t5_done1", {31'b0, bus.result_valid}, 32'd1);
        chk("t5_one_pulse", ov_cnt, 32'd1);
        chk("t5_idx1",   {28'b0, bus.class_idx}, 32'd4);
        chk("t5_score1", {16'b0, bus.max_score}, 32'h0700);
        bus.scores_valid = 1'b0;
        step();
        bus.scores_valid = 1'b1;
        step();
        bus.scores_valid = 1'b0;
        chk("t5_done_overrun", {31'b0, bus.overrun},      32'd1);
        chk("t5_discard",      {31'b0, bus.result_valid}, 32'd0);
        chk("t5_rescan",       {31'b0, bus.busy},         32'd1);
        wait_done("t5_done2");
        chk("t5_idx2",   {28'b0, bus.class_idx}, 32'd1);
        chk("t5_score2", {16'b0, bus.max_score}, 32'h7000);
        ack_result();

        // 6: reset mid-scan; scores_valid high across release starts a frame
        for (int k = 0; k < 10; k++) s[k] = 16'h0050;
        s[6] = 16'h0321;
        bus.scores = s;
        bus.scores_valid = 1'b1;
        step();
        bus.scores_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        for (int k = 0; k < 10; k++) s_b[k] = 16'hFFF0;
        s_b[0] = 16'h0001;
        bus.scores = s_b;
        bus.scores_valid = 1'b1;
        rst = 1'b1;
        step();
        chk("t6_rst_valid", {31'b0, bus.result_valid}, 32'd0);
        chk("t6_rst_idx",   {28'b0, bus.class_idx},    32'd0);
        chk("t6_rst_score", {16'b0, bus.max_score},    32'd0);
        chk("t6_rst_busy",  {31'b0, bus.busy},         32'd0);
        chk("t6_rst_ovr",   {31'b0, bus.overrun},      32'd0);
        rst = 1'b0;
        step();
        chk("t6_release_frame", {31'b0, bus.busy}, 32'd1);
        bus.scores_valid = 1'b0;
        wait_done("t6_done");
        chk("t6_idx",   {28'b0, bus.class_idx}, 32'd0);
        chk("t6_score", {16'b0, bus.max_score}, 32'h0001);
        ack_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
